fpu_issue: RTL and testbench
============================

# fpu_issue

Issue/writeback stage in front of the fixed-point processing unit (`Fpu`). It accepts one arithmetic instruction at a time from the decoder over a valid/ready handshake and reads both operands from an internal 32×64 Q15.48 register file. It drives `fpu_op`, `a_data` and `b_data` into the FPU, sequences the multi-cycle divide via `fpu_busy`, and writes `fpu_res` back to the register file. It also provides the load/store path into that register file.

## Interface
Parameters:
- `NREG`, 32: register-file depth; 5-bit index.
- `XLEN`, 64: datum width; Q15.48 signed, 1.0 = 64'h0001000000000000.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: decoder presents an instruction.
- `in_ready` out 1: stage can accept.
- `in_op` in 4: FPU opcode.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: destination and source register indices.
- `ld_valid` in 1: load writes the register file.
- `ld_ready` out 1: load accepted this cycle.
- `ld_addr` in 5: load destination index.
- `ld_data` in 64: load data.
- `st_addr` in 5: store read index.
- `st_data` out 64: combinational read of `rf[st_addr]`, with the writeback bypass below.
- `fpu_op` out 4: opcode to FPU, registered.
- `a_data`, `b_data` out 64: operands to FPU, registered.
- `fpu_busy` in 1: divider busy.
- `fpu_res` in 64: FPU result.
- `done` out 1: one-cycle pulse when a result is written.
- `done_rd` out 5: register written; valid with `done`.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- States: IDLE, EXEC, DIV_WAIT, WB.
- IDLE:
  - `in_ready` = (state==IDLE) & !fpu_busy.
  - On accept, latch `rd`.
  - Latch `a_data` = rf[rs1] and `b_data` = rf[rs2], with a bypass from a same-cycle load write to the same index.
  - Latch `fpu_op` = `in_op`.
- Legal opcodes: 0000–0110, 1000–1010, 1100, 1101. Any other opcode:
  - pulse `illegal` on the accept edge;
  - stay in IDLE;
  - perform no register-file write.
- EXEC:
  - Non-divide: capture `fpu_res` into `res_q`, then go to WB.
  - Divide (0011): go to DIV_WAIT. The FPU launches itself while op==0011 and !busy.
- DIV_WAIT:
  - Hold `fpu_op`, `a_data` and `b_data` stable.
  - Stay while `fpu_busy`==1.
  - In the first cycle with `fpu_busy`==0, capture `fpu_res`, then go to WB.
- WB:
  - Write `res_q` to rf[rd].
  - Pulse `done` with `done_rd`=rd.
  - Drive `fpu_op` to 4'b0000 and zero `a_data`/`b_data`.
  - Go to IDLE.
- Load port:
  - `ld_ready` = !(state==WB).
  - FPU writeback has priority over a load.
  - If a load and WB target the same cycle, the load stalls one cycle.
- Store bypass: if WB writes `st_addr` this cycle, `st_data` returns `res_q`.
- Register-file reset: `reset` clears all 32 entries to 0. No register is hardwired.
- Comparisons (1000–1010) write 1.0 or 0.0 as produced by the FPU. This stage passes results through unmodified.

## Timing
- Reset values:
  - state = IDLE;
  - `in_ready` = 1 (if `fpu_busy`=0);
  - `ld_ready` = 1;
  - `fpu_op` = 0000;
  - `a_data` = `b_data` = 0;
  - `done` = `illegal` = 0;
  - `done_rd` = 0;
  - `st_data` = 0.
- Non-divide op:
  - accept at edge T;
  - operands valid at the FPU during cycle T+1;
  - result captured at edge T+1, written at edge T+2;
  - `done` high in cycle T+2.
  - Throughput: one op per 3 cycles.
- Divide op:
  - `fpu_busy` must rise the cycle after EXEC;
  - the write occurs one cycle after the first `fpu_busy`==0 cycle in DIV_WAIT.
- Divide relaunch: the FPU may relaunch in the capture cycle. The next instruction is therefore held off by `in_ready`'s `!fpu_busy` term, and `fpu_op`=0000 in WB ends the spurious relaunch condition.
- Reset mid-operation: aborts with no write and no `done`, and clears the register file. Synchronous reset does not stop an in-flight divider; `in_ready` stays low until `fpu_busy` drops.
- Back-to-back dependency: a dependent instruction can be accepted no earlier than the cycle after WB. It then reads the written value directly from the register file; no extra forwarding is needed.

## Structure
- Shared package `fpu_pkg`:
  - opcode localparams (`FPU_ADD`=0000 … `FPU_MAX`=1101);
  - `Q_ONE`=64'h0001000000000000;
  - state enum;
  - `is_legal_op()` function.
- One sub-module, `fpu_regfile`:
  - 32×64;
  - two combinational read ports plus a store read port;
  - one write port with a priority mux between WB and load;
  - synchronous clear on reset.

## Test plan
- Reset, then load rf[1]=0x0002_0000_0000_0000 (2.0) and rf[2]=0x0003_0000_0000_0000 (3.0). Issue op 0010, rd=3 → `done` at T+2, `done_rd`=3, rf[3]=0x0006_0000_0000_0000.
- Divide rf[3]/rf[1] (op 0011) → `in_ready` low for the whole divide; rf[rd]=0x0003_0000_0000_0000; exactly one `done`.
- Opcode 0111 → `illegal` pulses once, no write, `in_ready` high the next cycle.
- Load to rf[5] in the same cycle as WB to rf[5] → `ld_ready`=0 that cycle; the load lands one cycle later and the final rf[5] equals the load data.
- Issue op 1001 with rf[1]=2.0, rf[2]=3.0 → result 1.0. Then issue with rs1 and rs2 swapped → result 0.
- Assert `reset` during DIV_WAIT → no `done`; rf all zero; `in_ready` returns only after `fpu_busy` falls.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue/writeback stage: opcodes, Q15.48 constants,
// FSM state encoding and the opcode legality check.
package fpu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] FPU_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] FPU_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] FPU_MUL  = 4'b0010;
    localparam logic [OP_W-1:0] FPU_DIV  = 4'b0011;
    localparam logic [OP_W-1:0] FPU_NEG  = 4'b0100;
    localparam logic [OP_W-1:0] FPU_ABS  = 4'b0101;
    localparam logic [OP_W-1:0] FPU_MOV  = 4'b0110;
    localparam logic [OP_W-1:0] FPU_EQ   = 4'b1000;
    localparam logic [OP_W-1:0] FPU_LT   = 4'b1001;
    localparam logic [OP_W-1:0] FPU_LE   = 4'b1010;
    localparam logic [OP_W-1:0] FPU_MIN  = 4'b1100;
    localparam logic [OP_W-1:0] FPU_MAX  = 4'b1101;

    localparam logic [63:0] Q_ONE = 64'h0001_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV_WAIT,
        ST_WB
    } state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= FPU_MOV) || ((op >= FPU_EQ) && (op <= FPU_LE)) ||
               (op == FPU_MIN) || (op == FPU_MAX);
    endfunction

endpackage

// File: rtl/fpu_regfile.sv
// 32x64 register file: two operand read ports with load bypass, a store read port
// with writeback bypass, and one write port where writeback beats a load.
module fpu_regfile #(
    parameter int unsigned NREG = 32,
    parameter int unsigned XLEN = 64,
    localparam int unsigned AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   st_addr,
    output logic [XLEN-1:0] st_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] mem [NREG];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    always_comb begin
        wr_en   = wb_en | ld_en;
        wr_addr = wb_en ? wb_addr : ld_addr;
        wr_data = wb_en ? wb_data : ld_data;
    end

    // Operands see a load landing on the same edge they are latched.
    assign rs1_data = (ld_en && (ld_addr == rs1_addr)) ? ld_data : mem[rs1_addr];
    assign rs2_data = (ld_en && (ld_addr == rs2_addr)) ? ld_data : mem[rs2_addr];
    assign st_data  = (wb_en && (wb_addr == st_addr)) ? wb_data : mem[st_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/fpu_issue.sv
// Issue/writeback stage in front of the fixed-point unit: operand fetch, divide
// sequencing on fpu_busy, result writeback and the load/store register-file path.
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned XLEN = 64,
    localparam int unsigned AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [AW-1:0]   in_rd,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic [AW-1:0]   st_addr,
    output logic [XLEN-1:0] st_data,
    output logic [OP_W-1:0] fpu_op,
    output logic [XLEN-1:0] a_data,
    output logic [XLEN-1:0] b_data,
    input  logic            fpu_busy,
    input  logic [XLEN-1:0] fpu_res,
    output logic            done,
    output logic [AW-1:0]   done_rd,
    output logic            illegal
);

    state_t          state, state_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [OP_W-1:0] op_d;
    logic [XLEN-1:0] a_d, b_d;
    logic            done_d, illegal_d;
    logic [AW-1:0]   done_rd_d;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            accept, ld_en, wb_en;

    // A relaunched divider keeps fpu_busy high past WB, holding off the next issue.
    assign in_ready = (state == ST_IDLE) && !fpu_busy;
    assign ld_ready = (state != ST_WB);
    assign accept   = in_valid && in_ready;
    assign ld_en    = ld_valid && ld_ready;
    assign wb_en    = (state == ST_WB);

    fpu_regfile #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (in_rs1),
        .rs2_addr (in_rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .wb_en    (wb_en),
        .wb_addr  (rd_q),
        .wb_data  (res_q),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d   = state;
        rd_d      = rd_q;
        res_d     = res_q;
        op_d      = fpu_op;
        a_d       = a_data;
        b_d       = b_data;
        done_d    = 1'b0;
        done_rd_d = done_rd;
        illegal_d = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_legal_op(in_op)) begin
                        state_d = ST_EXEC;
                        rd_d    = in_rd;
                        op_d    = in_op;
                        a_d     = rs1_data;
                        b_d     = rs2_data;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                if (fpu_op == FPU_DIV) begin
                    state_d = ST_DIV_WAIT;
                end else begin
                    state_d   = ST_WB;
                    res_d     = fpu_res;
                    op_d      = '0;
                    a_d       = '0;
                    b_d       = '0;
                    done_d    = 1'b1;
                    done_rd_d = rd_q;
                end
            end
            ST_DIV_WAIT: begin
                // Operands stay put until the divider reports completion.
                if (!fpu_busy) begin
                    state_d   = ST_WB;
                    res_d     = fpu_res;
                    op_d      = '0;
                    a_d       = '0;
                    b_d       = '0;
                    done_d    = 1'b1;
                    done_rd_d = rd_q;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            rd_q    <= '0;
            res_q   <= '0;
            fpu_op  <= '0;
            a_data  <= '0;
            b_data  <= '0;
            done    <= 1'b0;
            done_rd <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            fpu_op  <= op_d;
            a_data  <= a_d;
            b_data  <= b_d;
            done    <= done_d;
            done_rd <= done_rd_d;
            illegal <= illegal_d;
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: behavioural FPU plus a transaction-level model of the stage,
// checked every cycle, with directed scenarios followed by random traffic.
module tb_fpu_issue;
    import fpu_pkg::*;

    localparam int unsigned DIV_LAT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [63:0] ld_data = '0;
    logic [4:0]  st_addr = '0;
    logic        in_ready, ld_ready, done, illegal, fpu_busy;
    logic [63:0] st_data, a_data, b_data, fpu_res;
    logic [3:0]  fpu_op;
    logic [4:0]  done_rd;

    fpu_issue dut (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready), .in_op (in_op),
        .in_rd (in_rd), .in_rs1 (in_rs1), .in_rs2 (in_rs2),
        .ld_valid (ld_valid), .ld_ready (ld_ready), .ld_addr (ld_addr), .ld_data (ld_data),
        .st_addr (st_addr), .st_data (st_data),
        .fpu_op (fpu_op), .a_data (a_data), .b_data (b_data),
        .fpu_busy (fpu_busy), .fpu_res (fpu_res),
        .done (done), .done_rd (done_rd), .illegal (illegal)
    );

    always #5 clk = ~clk;

    // Q15.48 arithmetic as the FPU defines it.
    function automatic logic [63:0] fpu_func(input logic [3:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
        logic signed [63:0]  sa, sb;
        logic signed [127:0] w;
        sa = a;
        sb = b;
        case (op)
            FPU_ADD: return sa + sb;
            FPU_SUB: return sa - sb;
            FPU_MUL: begin w = 128'(sa) * 128'(sb); return w[111:48]; end
            FPU_DIV: begin
                if (sb == 0) return 64'h7FFF_FFFF_FFFF_FFFF;
                w = (128'(sa) <<< 48) / 128'(sb);
                return w[63:0];
            end
            FPU_NEG: return -sa;
            FPU_ABS: return (sa < 0) ? -sa : sa;
            FPU_MOV: return a;
            FPU_EQ:  return (sa == sb) ? Q_ONE : 64'd0;
            FPU_LT:  return (sa < sb) ? Q_ONE : 64'd0;
            FPU_LE:  return (sa <= sb) ? Q_ONE : 64'd0;
            FPU_MIN: return (sa < sb) ? a : b;
            FPU_MAX: return (sa < sb) ? b : a;
            default: return 64'd0;
        endcase
    endfunction

    // Divider: launches whenever it sees a divide while idle, ignores reset.
    int unsigned busy_cnt = 0;
    logic [63:0] div_q = '0;
    always @(posedge clk) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (fpu_op == FPU_DIV) begin
            busy_cnt <= DIV_LAT;
            div_q    <= fpu_func(FPU_DIV, a_data, b_data);
        end
    end
    assign fpu_busy = (busy_cnt != 0);
    always_comb fpu_res = (fpu_op == FPU_DIV) ? div_q : fpu_func(fpu_op, a_data, b_data);

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0, ill_cnt = 0;
    int done_cyc = 0, acc_cyc = 0, ld_acc_cyc = 0;
    bit in_acc_last = 0, ld_acc_last = 0;

    // Reference model: register array plus one outstanding instruction on a timeline.
    logic [63:0] m_rf [32];
    bit          armed = 0, pend = 0, ill_flag = 0;
    int          exec_cyc = 0, wb_cyc = 0;
    logic [4:0]  p_rd = '0;
    logic [3:0]  p_op = '0;
    logic [63:0] p_a = '0, p_b = '0, p_res = '0;
    logic signed [63:0] rnd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the model to the next rising edge.
    task automatic step();
        bit wb_now, exp_in_ready;
        logic [63:0] exp_st;
        @(negedge clk);
        in_acc_last = in_valid && in_ready;
        ld_acc_last = ld_valid && ld_ready;
        if (in_acc_last) acc_cyc = cyc;
        if (ld_acc_last) ld_acc_cyc = cyc;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (illegal) ill_cnt++;
        wb_now       = pend && (cyc == wb_cyc);
        exp_in_ready = !pend && !fpu_busy;
        if (armed) begin
            exp_st = (wb_now && (p_rd == st_addr)) ? p_res : m_rf[st_addr];
            check("in_ready", 64'(in_ready), 64'(exp_in_ready));
            check("ld_ready", 64'(ld_ready), 64'(!wb_now));
            check("done", 64'(done), 64'(wb_now));
            check("illegal", 64'(illegal), 64'(ill_flag));
            check("st_data", st_data, exp_st);
            if (wb_now) begin
                check("done_rd", 64'(done_rd), 64'(p_rd));
                check("wb_op_zero", 64'(fpu_op), 64'd0);
                check("wb_a_zero", a_data, 64'd0);
                check("wb_b_zero", b_data, 64'd0);
            end
            if (pend && (cyc == exec_cyc)) begin
                check("exec_op", 64'(fpu_op), 64'(p_op));
                check("exec_a", a_data, p_a);
                check("exec_b", b_data, p_b);
            end
        end
        if (reset) begin
            armed    = 1;
            pend     = 0;
            ill_flag = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
        end else if (armed) begin
            ill_flag = 0;
            if (wb_now) begin
                m_rf[p_rd] = p_res;
                pend = 0;
            end else if (ld_valid) begin
                m_rf[ld_addr] = ld_data;
            end
            if (in_valid && exp_in_ready) begin
                if (in_op inside {[4'd0:4'd6], [4'd8:4'd10], 4'd12, 4'd13}) begin
                    pend     = 1;
                    p_op     = in_op;
                    p_rd     = in_rd;
                    p_a      = m_rf[in_rs1];
                    p_b      = m_rf[in_rs2];
                    p_res    = fpu_func(in_op, p_a, p_b);
                    exec_cyc = cyc + 1;
                    wb_cyc   = (in_op == FPU_DIV) ? cyc + 3 + int'(DIV_LAT) : cyc + 2;
                end else begin
                    ill_flag = 1;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2);
        int k;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_valid = 1'b1;
        k = 0;
        do begin step(); k++; end while (!in_acc_last && k < 200);
        in_valid = 1'b0;
        check("issue_accepted", 64'(in_acc_last), 64'd1);
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int start;
        start = done_cnt;
        for (int k = 0; k < 100 && done_cnt == start; k++) step();
        check({name, "_done_seen"}, 64'(done_cnt - start), 64'd1);
        check({name, "_latency"}, 64'(done_cyc - acc_cyc), 64'(exp_lat));
    endtask

    task automatic load(input logic [4:0] addr, input logic [63:0] data);
        ld_valid = 1'b1; ld_addr = addr; ld_data = data;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ld_acc_last) break;
        end
        ld_valid = 1'b0;
        check("load_accepted", 64'(ld_acc_last), 64'd1);
    endtask

    task automatic peek(input logic [4:0] addr, output logic [63:0] d);
        st_addr = addr;
        #1;
        d = st_data;
    endtask

    initial begin
        logic [63:0] v;
        int          base;
        step();
        step();
        reset = 1'b0;
        check("rst_fpu_op", 64'(fpu_op), 64'd0);
        check("rst_a", a_data, 64'd0);
        check("rst_b", b_data, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_done_rd", 64'(done_rd), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_ld_ready", 64'(ld_ready), 64'd1);
        check("rst_st_data", st_data, 64'd0);

        load(5'd1, 64'h0002_0000_0000_0000);
        load(5'd2, 64'h0003_0000_0000_0000);
        issue(FPU_MUL, 5'd3, 5'd1, 5'd2);
        wait_done("mul", 2);
        peek(5'd3, v);
        check("mul_rf3", v, 64'h0006_0000_0000_0000);

        base = done_cnt;
        issue(FPU_DIV, 5'd4, 5'd3, 5'd1);
        wait_done("div", 3 + int'(DIV_LAT));
        for (int k = 0; k < 10; k++) step();
        check("div_single_done", 64'(done_cnt - base), 64'd1);
        peek(5'd4, v);
        check("div_rf4", v, 64'h0003_0000_0000_0000);

        base = ill_cnt;
        issue(4'b0111, 5'd6, 5'd1, 5'd2);
        step();
        check("illegal_pulses", 64'(ill_cnt - base), 64'd1);
        check("illegal_ready_after", 64'(in_ready), 64'd1);
        peek(5'd6, v);
        check("illegal_no_write", v, 64'd0);

        issue(FPU_ADD, 5'd5, 5'd1, 5'd2);
        step();
        ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 64'h0000_1234_5678_9ABC;
        #1;
        check("wb_cycle_ld_ready", 64'(ld_ready), 64'd0);
        for (int k = 0; k < 20; k++) begin
            step();
            if (ld_acc_last) break;
        end
        ld_valid = 1'b0;
        check("stalled_load_cycle", 64'(ld_acc_cyc - acc_cyc), 64'd3);
        peek(5'd5, v);
        check("load_after_wb_rf5", v, 64'h0000_1234_5678_9ABC);

        issue(FPU_LT, 5'd7, 5'd1, 5'd2);
        wait_done("lt", 2);
        peek(5'd7, v);
        check("lt_true", v, Q_ONE);
        issue(FPU_LT, 5'd7, 5'd2, 5'd1);
        wait_done("lt_swap", 2);
        peek(5'd7, v);
        check("lt_false", v, 64'd0);

        base = done_cnt;
        issue(FPU_DIV, 5'd9, 5'd2, 5'd1);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_div_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 32; i++) begin
            peek(5'(i), v);
            check("rst_rf_clear", v, 64'd0);
            step();
        end
        check("rst_mid_div_no_done", 64'(done_cnt - base), 64'd0);
        check("rst_ready_after_busy", 64'(in_ready), 64'd1);

        for (int n = 0; n < 1500; n++) begin
            st_addr = 5'($urandom_range(0, 7));
            reset   = ($urandom_range(0, 399) == 0);
            if (in_valid && in_acc_last) in_valid = 1'b0;
            if (!in_valid && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b1;
                in_op    = 4'($urandom_range(0, 15));
                in_rd    = 5'($urandom_range(0, 7));
                in_rs1   = 5'($urandom_range(0, 7));
                in_rs2   = 5'($urandom_range(0, 7));
            end
            if (ld_valid && ld_acc_last) ld_valid = 1'b0;
            if (!ld_valid && $urandom_range(0, 2) == 0) begin
                rnd      = {$urandom(), $urandom()};
                ld_valid = 1'b1;
                ld_addr  = 5'($urandom_range(0, 7));
                ld_data  = rnd >>> 12;
            end
            step();
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        ld_valid = 1'b0;
        for (int k = 0; k < 20; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
